// File: rtl/mt_ctrl_if.sv
// Handshake and state-memory bus between the MT controller and its driver.
// The slave modport is the controller; the master modport is the twist engine/host side.
interface mt_ctrl_if;
  logic        start;
  logic [31:0] seed;
  logic        rn_req;
  logic        done_twist;
  logic        valid_rn;
  logic [1:0]  current_state;
  logic        seed_we;
  logic [9:0]  seed_addr;
  logic [31:0] seed_data;
  logic        busy;
  logic        seeded;
  logic        block_done;
  logic [9:0]  rn_count;
  logic        count_err;

  modport master (
    output start, seed, rn_req, done_twist, valid_rn,
    input  current_state, seed_we, seed_addr, seed_data,
    input  busy, seeded, block_done, rn_count, count_err
  );

  modport slave (
    input  start, seed, rn_req, done_twist, valid_rn,
    output current_state, seed_we, seed_addr, seed_data,
    output busy, seeded, block_done, rn_count, count_err
  );
endinterface

// File: rtl/mt_ctrl.sv
// Mersenne-Twister sequencing controller: seeds the state memory, then runs
// twist blocks on request, counting tempered outputs and flagging short blocks.
module mt_ctrl #(
  parameter int unsigned N            = 624,
  parameter logic [31:0] INIT_MULT    = 32'd1812433253,
  parameter int unsigned DRAIN_CYCLES = 5,
  parameter int unsigned EXPECTED_RN  = 624
) (
  input logic      clk,
  input logic      rst_n,
  mt_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_TWIST,
    S_TWIST_WRAP,
    S_DRAIN,
    S_READY
  } state_t;

  localparam logic [1:0] MODE_IDLE  = 2'b00;
  localparam logic [1:0] MODE_SEED  = 2'b01;
  localparam logic [1:0] MODE_TWIST = 2'b10;
  localparam logic [1:0] MODE_DRAIN = 2'b11;

  localparam logic [9:0] ADDR_LAST  = 10'(N - 1);
  localparam logic [9:0] RN_EXPECT  = 10'(EXPECTED_RN);
  localparam logic [9:0] RN_MAX     = 10'd1023;
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

  state_t      state;
  logic [7:0]  drain_cnt;
  logic        pending;
  logic [1:0]  current_state;
  logic        seed_we;
  logic [9:0]  seed_addr;
  logic [31:0] seed_data;
  logic        busy;
  logic        seeded;
  logic        block_done;
  logic [9:0]  rn_count;
  logic        count_err;

  logic [31:0] seed_mix;
  logic [31:0] seed_next;
  logic [9:0]  rn_next;

  // Next seed word is derived from the word currently on the write port.
  always_comb begin
    seed_mix  = seed_data ^ (seed_data >> 30);
    seed_next = INIT_MULT * seed_mix + {22'd0, seed_addr} + 32'd1;
    rn_next   = rn_count;
    if (bus.valid_rn && (rn_count != RN_MAX)) begin
      rn_next = rn_count + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      drain_cnt     <= 8'd0;
      pending       <= 1'b0;
      current_state <= MODE_IDLE;
      seed_we       <= 1'b0;
      seed_addr     <= 10'd0;
      seed_data     <= 32'd0;
      busy          <= 1'b0;
      seeded        <= 1'b0;
      block_done    <= 1'b0;
      rn_count      <= 10'd0;
      count_err     <= 1'b0;
    end else begin
      block_done <= 1'b0;

      if (state inside {S_TWIST, S_TWIST_WRAP, S_DRAIN}) begin
        rn_count <= rn_next;
        if (bus.rn_req) begin
          pending <= 1'b1;
        end
      end

      case (state)
        S_IDLE, S_READY: begin
          // Start takes priority; a same-cycle or pending request is dropped.
          if (bus.start) begin
            state         <= S_SEED;
            current_state <= MODE_SEED;
            busy          <= 1'b1;
            seeded        <= 1'b0;
            pending       <= 1'b0;
            seed_we       <= 1'b1;
            seed_addr     <= 10'd0;
            seed_data     <= bus.seed;
          end else if ((state == S_READY) && (pending || bus.rn_req)) begin
            state         <= S_TWIST;
            current_state <= MODE_TWIST;
            busy          <= 1'b1;
            pending       <= 1'b0;
            rn_count      <= 10'd0;
          end
        end

        S_SEED: begin
          if (seed_addr == ADDR_LAST) begin
            state         <= S_READY;
            current_state <= MODE_IDLE;
            busy          <= 1'b0;
            seeded        <= 1'b1;
            seed_we       <= 1'b0;
            seed_addr     <= 10'd0;
          end else begin
            seed_addr <= seed_addr + 10'd1;
            seed_data <= seed_next;
          end
        end

        S_TWIST: begin
          if (bus.done_twist) begin
            state <= S_TWIST_WRAP;
          end
        end

        S_TWIST_WRAP: begin
          state         <= S_DRAIN;
          current_state <= MODE_DRAIN;
          drain_cnt     <= 8'd0;
        end

        S_DRAIN: begin
          // The final drain cycle's strobe still counts toward the error check.
          if (drain_cnt == DRAIN_LAST) begin
            state         <= S_READY;
            current_state <= MODE_IDLE;
            busy          <= 1'b0;
            block_done    <= 1'b1;
            count_err     <= (rn_next != RN_EXPECT);
          end else begin
            drain_cnt <= drain_cnt + 8'd1;
          end
        end

        default: begin
          state         <= S_IDLE;
          current_state <= MODE_IDLE;
          busy          <= 1'b0;
          seed_we       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.current_state = current_state;
  assign bus.seed_we       = seed_we;
  assign bus.seed_addr     = seed_addr;
  assign bus.seed_data     = seed_data;
  assign bus.busy          = busy;
  assign bus.seeded        = seeded;
  assign bus.block_done    = block_done;
  assign bus.rn_count      = rn_count;
  assign bus.count_err     = count_err;

endmodule

// File: tb/tb_mt_ctrl.sv
// Directed bench for mt_ctrl: seeding, block sequencing, pending requests,
// count saturation and asynchronous reset.
module tb_mt_ctrl;
  localparam int N     = 624;
  localparam int DRAIN = 5;
  localparam logic [31:0] MULT = 32'd1812433253;

  logic clk;
  logic rst_n;
  int   numChecks;
  int   numFails;

  mt_ctrl_if bus();

  mt_ctrl #(
    .N(N),
    .INIT_MULT(MULT),
    .DRAIN_CYCLES(DRAIN),
    .EXPECTED_RN(624)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic [31:0] sd, input logic req,
                               input logic dn, input logic vld);
    bus.start      = st;
    bus.seed       = sd;
    bus.rn_req     = req;
    bus.done_twist = dn;
    bus.valid_rn   = vld;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mtNext(input logic [31:0] w, input int idx);
    return MULT * (w ^ (w >> 30)) + 32'(idx);
  endfunction

  // Full seeding pass; stray start/rn_req pulses mid-seed must not disturb it.
  task automatic seedRun(input logic [31:0] s, input logic [31:0] word1, input bit withReq);
    logic [31:0] w;
    int bad;
    applyStimulus(1'b1, s, withReq, 1'b0, 1'b0);
    tick;
    applyStimulus(1'b0, s, 1'b0, 1'b0, 1'b0);
    checkOutput("seed_entry_mode", bus.current_state, 2'b01);
    checkOutput("seed_entry_busy", bus.busy, 1'b1);
    checkOutput("seed_addr0_data", bus.seed_data, s);
    w = s;
    bad = 0;
    for (int i = 0; i < N; i++) begin
      if (bus.seed_we !== 1'b1 || bus.seed_addr !== 10'(i) ||
          bus.seed_data !== w || bus.current_state !== 2'b01) bad++;
      if (i == 1) checkOutput("seed_addr1_data", bus.seed_data, word1);
      if (i == N - 1) checkOutput("seed_last_addr", bus.seed_addr, 32'(N - 1));
      w = mtNext(w, i + 1);
      applyStimulus(i == 100, (i == 100) ? 32'd7 : s, i == 200, 1'b0, 1'b0);
      tick;
    end
    checkOutput("seed_words", bad, 0);
    checkOutput("seed_we_low", bus.seed_we, 1'b0);
    checkOutput("seed_seeded", bus.seeded, 1'b1);
    checkOutput("seed_done_mode", bus.current_state, 2'b00);
    checkOutput("seed_done_busy", bus.busy, 1'b0);
    checkOutput("seed_addr_wrap", bus.seed_addr, 10'd0);
  endtask

  // One twist block: valid_rn pulses end on the final drain cycle.
  task automatic blockRun(input string name, input int nValid, input int doneAt,
                          input bit viaPending, input bit extras);
    int last, first, pulses, badMode, badCount, finalCount;
    logic [1:0] expMode;
    logic [9:0] expCount;
    last  = doneAt + 1 + DRAIN;
    first = last - nValid + 1;
    if (!viaPending) applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    tick;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    checkOutput({name, "_entry_mode"}, bus.current_state, 2'b10);
    checkOutput({name, "_entry_count"}, bus.rn_count, 10'd0);
    pulses = 0;
    badMode = 0;
    badCount = 0;
    for (int k = 0; k <= last; k++) begin
      expMode = (k <= doneAt + 1) ? 2'b10 : 2'b11;
      if (bus.current_state !== expMode || bus.busy !== 1'b1 || bus.block_done !== 1'b0) badMode++;
      expCount = (pulses > 1023) ? 10'd1023 : 10'(pulses);
      if (bus.rn_count !== expCount) badCount++;
      applyStimulus(extras && (k == doneAt + 3), 32'd99, extras && (k == 10 || k == 20),
                    k == doneAt, k >= first);
      if (k >= first) pulses++;
      tick;
    end
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    finalCount = (nValid > 1023) ? 1023 : nValid;
    checkOutput({name, "_mode_seq"}, badMode, 0);
    checkOutput({name, "_count_trace"}, badCount, 0);
    checkOutput({name, "_block_done"}, bus.block_done, 1'b1);
    checkOutput({name, "_ready_mode"}, bus.current_state, 2'b00);
    checkOutput({name, "_ready_busy"}, bus.busy, 1'b0);
    checkOutput({name, "_rn_count"}, bus.rn_count, 32'(finalCount));
    checkOutput({name, "_count_err"}, bus.count_err, (finalCount != 624) ? 1 : 0);
    checkOutput({name, "_seeded"}, bus.seeded, 1'b1);
  endtask

  initial begin
    numChecks = 0;
    numFails  = 0;
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_mode", bus.current_state, 2'b00);
    checkOutput("rst_seed_we", bus.seed_we, 1'b0);
    checkOutput("rst_busy", bus.busy, 1'b0);
    checkOutput("rst_seeded", bus.seeded, 1'b0);
    checkOutput("rst_rn_count", bus.rn_count, 10'd0);
    checkOutput("rst_count_err", bus.count_err, 1'b0);
    rst_n = 1'b1;
    tick;
    tick;
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    tick;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    tick;
    checkOutput("idle_req_ignored_mode", bus.current_state, 2'b00);
    checkOutput("idle_req_ignored_busy", bus.busy, 1'b0);

    seedRun(32'd1, 32'd1812433254, 1'b0);

    blockRun("blkA", 624, 623, 1'b0, 1'b0);
    tick;
    checkOutput("blkA_done_width", bus.block_done, 1'b0);
    checkOutput("blkA_stays_ready", bus.current_state, 2'b00);

    blockRun("blkB", 620, 623, 1'b0, 1'b1);
    blockRun("blkC", 624, 623, 1'b1, 1'b0);
    tick;
    checkOutput("no_second_extra", bus.current_state, 2'b00);
    checkOutput("blkC_done_width", bus.block_done, 1'b0);

    blockRun("blkSat", 1030, 1030, 1'b0, 1'b0);

    seedRun(32'd5489, 32'd1301868182, 1'b1);

    // Reset in the middle of a seeding pass.
    applyStimulus(1'b1, 32'd5489, 1'b0, 1'b0, 1'b0);
    tick;
    applyStimulus(1'b0, 32'd5489, 1'b0, 1'b0, 1'b0);
    repeat (300) tick;
    checkOutput("pre_reset_addr", bus.seed_addr, 10'd300);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_mode", bus.current_state, 2'b00);
    checkOutput("async_rst_seed_we", bus.seed_we, 1'b0);
    checkOutput("async_rst_addr", bus.seed_addr, 10'd0);
    checkOutput("async_rst_data", bus.seed_data, 32'd0);
    checkOutput("async_rst_busy", bus.busy, 1'b0);
    checkOutput("async_rst_seeded", bus.seeded, 1'b0);
    checkOutput("async_rst_rn_count", bus.rn_count, 10'd0);
    checkOutput("async_rst_count_err", bus.count_err, 1'b0);
    checkOutput("async_rst_block_done", bus.block_done, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick;
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    tick;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    tick;
    checkOutput("post_rst_req_mode", bus.current_state, 2'b00);
    checkOutput("post_rst_req_busy", bus.busy, 1'b0);
    checkOutput("post_rst_seeded", bus.seeded, 1'b0);
    checkOutput("post_rst_seed_we", bus.seed_we, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end
endmodule
